// File: rtl/sys_types_pkg.sv
// Shared scalar types and fixed-point constants for the post-array datapath units
// (requantization, pooling, averaging).
package sys_types;

    typedef logic signed [31:0] int32_t;
    typedef logic signed [7:0]  int8_t;

    localparam int                 QUANT_SHIFT_BITS = 6;
    localparam logic signed [63:0] Q31_ONE_HALF     = 64'sd1 << 30;
    localparam int32_t             INT32_MAX        = 32'sh7FFF_FFFF;
    localparam int32_t             INT32_MIN        = 32'sh8000_0000;

endpackage

// File: rtl/rounding_divide_by_pot.sv
// Combinational divide of a signed int32 by 2^e, rounding halves away from zero.
// Shared by the requantize, pooling and averaging datapaths.
module rounding_divide_by_pot
    import sys_types::*;
(
    input  int32_t     h_i,
    input  logic [4:0] e_i,
    output int32_t     r_o
);

    logic [31:0] mask;
    logic [31:0] rem;
    logic [31:0] thr;
    int32_t      shifted;

    // Negative values get a threshold one higher, so an exact half on the
    // floor-shifted result still moves toward negative infinity (away from zero).
    always_comb begin : roundDivide
        mask    = (32'd1 << e_i) - 32'd1;
        rem     = $unsigned(h_i) & mask;
        thr     = (mask >> 1) + {31'd0, h_i[31]};
        shifted = h_i >>> e_i;
        r_o     = shifted + ((rem > thr) ? 32'sd1 : 32'sd0);
    end

endmodule

// File: rtl/requant_activate_unit.sv
// Three-stage int32 -> int8 requantize + clamp activation with valid/ready backpressure.
// Define REQUANT_SAT_STATS_EN to add stats_clear/sat_count saturation statistics.
module requant_activate_unit
    import sys_types::*;
#(
    parameter int MAX_N  = 512,
    parameter int N_BITS = $clog2(MAX_N)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic signed [31:0]    in_output,
    input  logic [N_BITS-1:0]     in_row,
    input  logic [N_BITS-1:0]     in_col,
    output logic                  in_consume,
    input  logic signed [31:0]    quant_mult,
    input  logic signed [QUANT_SHIFT_BITS-1:0] quant_shift,
    input  logic signed [7:0]     out_zero_point,
    input  logic signed [7:0]     act_min,
    input  logic signed [7:0]     act_max,
`ifdef REQUANT_SAT_STATS_EN
    input  logic                  stats_clear,
    output logic [15:0]           sat_count,
`endif
    output logic                  out_valid,
    output logic signed [7:0]     out_data,
    output logic [N_BITS-1:0]     out_row,
    output logic [N_BITS-1:0]     out_col,
    input  logic                  out_ready,
    output logic                  idle
);

    logic              adv;
    logic              s1Valid_q, s2Valid_q, s3Valid_q;
    int32_t            s1X_q, s1X_d;
    int32_t            s2H_q, s2H_d;
    int8_t             s3Data_q, s3Data_d;
    logic [N_BITS-1:0] s1Row_q, s1Col_q, s2Row_q, s2Col_q, s3Row_q, s3Col_q;

    logic [2:0]         lshAmt;
    logic signed [38:0] xWide;
    logic signed [63:0] prod, rounded, biased;
    logic [4:0]         rdExp;
    int32_t             rdRes;
    logic signed [32:0] sumZp;
    logic               clampLow, clampHigh;

    // The whole pipe moves as one; in_valid is deliberately not involved so the
    // buffer's bypass path cannot close a combinational loop through us.
    assign adv        = ~s3Valid_q | out_ready;
    assign in_consume = adv;
    assign idle       = ~(s1Valid_q | s2Valid_q | s3Valid_q);

    always_comb begin : stage1Shift
        lshAmt = quant_shift[QUANT_SHIFT_BITS-1] ? 3'd0 : quant_shift[2:0];
        xWide  = {{7{in_output[31]}}, in_output};
        xWide  = xWide <<< lshAmt;
        if (xWide[38:31] != {8{xWide[31]}})
            s1X_d = xWide[38] ? INT32_MIN : INT32_MAX;
        else
            s1X_d = xWide[31:0];
    end

    // Negative sums are biased by 2^31-1 before the arithmetic shift so the
    // divide truncates toward zero rather than toward negative infinity.
    always_comb begin : stage2Mult
        prod    = 64'(s1X_q) * 64'(quant_mult);
        rounded = prod + (prod[63] ? (64'sd1 - Q31_ONE_HALF) : Q31_ONE_HALF);
        biased  = rounded + (rounded[63] ? 64'sd2147483647 : 64'sd0);
        s2H_d   = 32'(biased >>> 31);
        if (s1X_q == INT32_MIN && quant_mult == INT32_MIN)
            s2H_d = INT32_MAX;
    end

    always_comb begin : stage3Exp
        rdExp = quant_shift[QUANT_SHIFT_BITS-1] ? 5'(-quant_shift) : 5'd0;
    end

    rounding_divide_by_pot uRound (
        .h_i (s2H_q),
        .e_i (rdExp),
        .r_o (rdRes)
    );

    always_comb begin : stage3Clamp
        sumZp     = 33'(rdRes) + 33'(out_zero_point);
        clampLow  = sumZp < 33'(act_min);
        clampHigh = sumZp > 33'(act_max);
        if (clampLow)
            s3Data_d = act_min;
        else if (clampHigh)
            s3Data_d = act_max;
        else
            s3Data_d = sumZp[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1Valid_q <= 1'b0;
            s2Valid_q <= 1'b0;
            s3Valid_q <= 1'b0;
            s1X_q     <= '0;
            s2H_q     <= '0;
            s3Data_q  <= '0;
            s1Row_q   <= '0;
            s1Col_q   <= '0;
            s2Row_q   <= '0;
            s2Col_q   <= '0;
            s3Row_q   <= '0;
            s3Col_q   <= '0;
        end else if (adv) begin
            s1Valid_q <= in_valid;
            s1X_q     <= s1X_d;
            s1Row_q   <= in_row;
            s1Col_q   <= in_col;
            s2Valid_q <= s1Valid_q;
            s2H_q     <= s2H_d;
            s2Row_q   <= s1Row_q;
            s2Col_q   <= s1Col_q;
            s3Valid_q <= s2Valid_q;
            s3Data_q  <= s3Data_d;
            s3Row_q   <= s2Row_q;
            s3Col_q   <= s2Col_q;
        end
    end

    assign out_valid = s3Valid_q;
    assign out_data  = s3Data_q;
    assign out_row   = s3Row_q;
    assign out_col   = s3Col_q;

`ifdef REQUANT_SAT_STATS_EN
    logic        s3Sat_q;
    logic [15:0] satCount_q, satCount_d;

    // Clear beats a simultaneous increment; the count sticks at all-ones.
    always_comb begin : satNext
        satCount_d = satCount_q;
        if (stats_clear)
            satCount_d = '0;
        else if (s3Valid_q && out_ready && s3Sat_q && satCount_q != 16'hFFFF)
            satCount_d = satCount_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s3Sat_q    <= 1'b0;
            satCount_q <= '0;
        end else begin
            if (adv)
                s3Sat_q <= clampLow | clampHigh;
            satCount_q <= satCount_d;
        end
    end

    assign sat_count = satCount_q;
`endif

endmodule

// File: tb/tb_requant_activate_unit.sv
// Self-checking bench: spec vector table, backpressure/reset sequences and a randomized
// run against an arithmetic reference model. Sat-count checks need REQUANT_SAT_STATS_EN.
module tb_requant_activate_unit;

    localparam int N_BITS = 9;

    typedef struct {
        int acc;
        int mult;
        int sh;
        int zp;
        int amin;
        int amax;
        int expData;
    } vec_t;

    typedef struct {
        int data;
        int row;
        int col;
        int cyc;
        bit lat;
    } exp_t;

    typedef struct {
        int data;
        int row;
        int col;
        int cyc;
    } obs_t;

    logic                clk;
    logic                reset;
    logic                in_valid;
    logic signed [31:0]  in_output;
    logic [N_BITS-1:0]   in_row;
    logic [N_BITS-1:0]   in_col;
    logic                in_consume;
    logic signed [31:0]  quant_mult;
    logic signed [5:0]   quant_shift;
    logic signed [7:0]   out_zero_point;
    logic signed [7:0]   act_min;
    logic signed [7:0]   act_max;
    logic                out_valid;
    logic signed [7:0]   out_data;
    logic [N_BITS-1:0]   out_row;
    logic [N_BITS-1:0]   out_col;
    logic                out_ready;
    logic                idle;
`ifdef REQUANT_SAT_STATS_EN
    logic                stats_clear;
    logic [15:0]         sat_count;
`endif

    int   vecCount = 0;
    int   missCount = 0;
    int   cyc = 0;
    int   checkIdx = 0;
    bit   randReady = 0;
    int   cfgMult, cfgShift, cfgZp, cfgMin, cfgMax;
    exp_t expQ[$];
    obs_t obsQ[$];

    requant_activate_unit dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_output      (in_output),
        .in_row         (in_row),
        .in_col         (in_col),
        .in_consume     (in_consume),
        .quant_mult     (quant_mult),
        .quant_shift    (quant_shift),
        .out_zero_point (out_zero_point),
        .act_min        (act_min),
        .act_max        (act_max),
`ifdef REQUANT_SAT_STATS_EN
        .stats_clear    (stats_clear),
        .sat_count      (sat_count),
`endif
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_row        (out_row),
        .out_col        (out_col),
        .out_ready      (out_ready),
        .idle           (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Records every completed output handshake, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready)
            obsQ.push_back('{int'(out_data), int'(out_row), int'(out_col), cyc});
    end

    // Reference: real-number semantics of requantization using plain longint arithmetic.
    function automatic int refModel(input int acc, input int mult, input int sh,
                                    input int zp, input int amin, input int amax);
        longint x, p, h, d, q, rm, s;
        int     e;
        x = longint'(acc) * (longint'(1) << ((sh > 0) ? sh : 0));
        if (x > 64'sd2147483647)  x = 64'sd2147483647;
        if (x < -64'sd2147483648) x = -64'sd2147483648;
        if (x == -64'sd2147483648 && mult == 32'h8000_0000) begin
            h = 64'sd2147483647;
        end else begin
            p = x * longint'(mult);
            h = (p + ((p >= 0) ? (longint'(1) << 30) : (1 - (longint'(1) << 30))))
                / (longint'(1) << 31);
        end
        e  = (sh < 0) ? -sh : 0;
        d  = longint'(1) << e;
        q  = h / d;
        rm = h - q * d;
        if (e > 0 && 2 * ((rm < 0) ? -rm : rm) >= d)
            q = q + ((h < 0) ? -1 : 1);
        s = q + zp;
        if (s < amin) s = amin;
        if (s > amax) s = amax;
        return int'(s);
    endfunction

    task automatic expectEq(input string tag, input int actual, input int want);
        vecCount++;
        if (actual != want) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, want %0d", tag, actual, want);
        end
    endtask

    task automatic tickReady();
        if (randReady)
            out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic setConfig(input int mult, input int sh, input int zp,
                             input int amin, input int amax);
        cfgMult = mult; cfgShift = sh; cfgZp = zp; cfgMin = amin; cfgMax = amax;
        quant_mult     = mult;
        quant_shift    = 6'(sh);
        out_zero_point = 8'(zp);
        act_min        = 8'(amin);
        act_max        = 8'(amax);
    endtask

    // Holds one transfer on the input until it is consumed, then queues its expectation.
    task automatic applyStimulus(input int acc, input int row, input int col,
                                 input int expData, input bit lat);
        int   budget;
        exp_t e;
        budget    = 0;
        in_output = acc;
        in_row    = row[N_BITS-1:0];
        in_col    = col[N_BITS-1:0];
        in_valid  = 1'b1;
        forever begin
            @(negedge clk);
            if (in_consume) break;
            @(posedge clk); #1;
            tickReady();
            budget++;
            if (budget > 200) begin
                vecCount++;
                missCount++;
                $display("[TB] FAIL accept timeout: got in_consume=0 for %0d cycles, want 1", budget);
                in_valid = 1'b0;
                return;
            end
        end
        e = '{expData, row, col, cyc, lat};
        expQ.push_back(e);
        @(posedge clk); #1;
        tickReady();
        in_valid = 1'b0;
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        obs_t o;
        while (checkIdx < expQ.size() && checkIdx < obsQ.size()) begin
            e = expQ[checkIdx];
            o = obsQ[checkIdx];
            vecCount++;
            if (o.data != e.data || o.row != e.row || o.col != e.col) begin
                missCount++;
                $display("[TB] FAIL %s #%0d: got data=%0d row=%0d col=%0d, want data=%0d row=%0d col=%0d",
                         tag, checkIdx, o.data, o.row, o.col, e.data, e.row, e.col);
            end
            if (e.lat)
                expectEq({tag, " latency"}, o.cyc - e.cyc, 3);
            checkIdx++;
        end
    endtask

    task automatic waitDrain(input string tag);
        int budget;
        budget = 0;
        while (!(obsQ.size() >= expQ.size() && idle)) begin
            @(posedge clk); #1;
            tickReady();
            budget++;
            if (budget > 300) break;
        end
        expectEq({tag, " result count"}, obsQ.size(), expQ.size());
        checkOutput(tag);
    endtask

    initial begin
        vec_t vecs[17];
        int   accB[5];
        int   idx, budget, nBefore, acc, a, b;
        bit   changed;

        vecs = '{
            '{100,          32'h4000_0000,   0,   0, -128, 127,   50},
            '{101,          32'h4000_0000,   0,   0, -128, 127,   51},
            '{-100,         32'h4000_0000,   0,   0, -128, 127,  -50},
            '{1000,         32'h4000_0000,  -2,   0, -128, 127,  125},
            '{1002,         32'h4000_0000,  -2,   0, -128, 127,  125},
            '{1004,         32'h4000_0000,  -2,   0, -128, 127,  126},
            '{1006,         32'h4000_0000,  -2,   0, -128, 127,  126},
            '{-1004,        32'h4000_0000,  -2,   0, -128, 127, -126},
            '{-100,         32'h4000_0000,   0, -10,  -10, 127,  -10},
            '{40,           32'h4000_0000,   0, -10,  -10, 127,   10},
            '{1000,         32'h4000_0000,   0, -10,  -10, 127,  127},
            '{32'h8000_0000, 32'h8000_0000, -24,  0, -128, 127,  127},
            '{32'h4000_0000, 32'h4000_0000,  7,   0, -128, 127,  127},
            '{32'hC000_0000, 32'h4000_0000,  7,   0, -128, 127, -128},
            '{5,            32'h7FFF_FFFF,   0,   0,    0,   6,    5},
            '{9,            32'h7FFF_FFFF,   0,   0,    0,   6,    6},
            '{-3,           32'h7FFF_FFFF,   0,   0,    0,   6,    0}
        };

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_output = '0;
        in_row    = '0;
        in_col    = '0;
        out_ready = 1'b1;
`ifdef REQUANT_SAT_STATS_EN
        stats_clear = 1'b0;
`endif
        setConfig(32'h4000_0000, 0, 0, -128, 127);
        repeat (3) @(posedge clk);
        #1;
        expectEq("reset out_valid", int'(out_valid), 0);
        expectEq("reset idle", int'(idle), 1);
        expectEq("reset out_data", int'(out_data), 0);
        expectEq("reset out_row", int'(out_row), 0);
        expectEq("reset out_col", int'(out_col), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        $display("[TB] spec vector table");
        for (int i = 0; i < 17; i++) begin
            changed = (i == 0) || vecs[i].mult != cfgMult || vecs[i].sh != cfgShift ||
                      vecs[i].zp != cfgZp || vecs[i].amin != cfgMin || vecs[i].amax != cfgMax;
            if (changed) begin
                waitDrain("table");
                setConfig(vecs[i].mult, vecs[i].sh, vecs[i].zp, vecs[i].amin, vecs[i].amax);
            end
            applyStimulus(vecs[i].acc, i, 3 * i + 7, vecs[i].expData, 1'b1);
        end
        waitDrain("table");

`ifdef REQUANT_SAT_STATS_EN
        $display("[TB] saturation counter");
        setConfig(32'h4000_0000, 0, -10, -10, 127);
        stats_clear = 1'b1;
        @(posedge clk); #1;
        stats_clear = 1'b0;
        expectEq("sat_count cleared", int'(sat_count), 0);
        applyStimulus(-100, 1, 2, -10, 1'b1);
        applyStimulus(40, 3, 4, 10, 1'b1);
        applyStimulus(1000, 5, 6, 127, 1'b1);
        waitDrain("sat seq");
        expectEq("sat_count", int'(sat_count), 2);
`endif

        $display("[TB] backpressure");
        setConfig(32'h4000_0000, 0, 0, -128, 127);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) accB[k] = 37 * k - 61;
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            in_valid  = 1'b1;
            in_output = accB[(idx < 5) ? idx : 4];
            in_row    = N_BITS'(100 + idx);
            in_col    = N_BITS'(200 + idx);
            @(negedge clk);
            if (in_consume && idx < 5) begin
                expQ.push_back('{refModel(accB[idx], cfgMult, cfgShift, cfgZp, cfgMin, cfgMax),
                                 100 + idx, 200 + idx, cyc, 1'b0});
                idx++;
            end
            @(posedge clk); #1;
            if (c == 5)
                expectEq("bp hold data early", int'(out_data),
                         refModel(accB[0], cfgMult, cfgShift, cfgZp, cfgMin, cfgMax));
        end
        expectEq("bp accepted", idx, 3);
        expectEq("bp in_consume", int'(in_consume), 0);
        expectEq("bp out_valid", int'(out_valid), 1);
        expectEq("bp hold data", int'(out_data),
                 refModel(accB[0], cfgMult, cfgShift, cfgZp, cfgMin, cfgMax));
        expectEq("bp hold row", int'(out_row), 100);
        out_ready = 1'b1;
        budget = 0;
        while (idx < 5 && budget < 50) begin
            in_valid  = 1'b1;
            in_output = accB[idx];
            in_row    = N_BITS'(100 + idx);
            in_col    = N_BITS'(200 + idx);
            @(negedge clk);
            if (in_consume) begin
                expQ.push_back('{refModel(accB[idx], cfgMult, cfgShift, cfgZp, cfgMin, cfgMax),
                                 100 + idx, 200 + idx, cyc, 1'b0});
                idx++;
            end
            @(posedge clk); #1;
            budget++;
        end
        in_valid = 1'b0;
        expectEq("bp all accepted", idx, 5);
        budget = 0;
        while (obsQ.size() < expQ.size() && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        expectEq("bp idle after last", int'(idle), 1);
        waitDrain("backpressure");

        $display("[TB] reset mid-flight");
        nBefore = obsQ.size();
        applyStimulus(77, 11, 12, 0, 1'b0);
        applyStimulus(88, 13, 14, 0, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        void'(expQ.pop_back());
        void'(expQ.pop_back());
        expectEq("midreset out_valid", int'(out_valid), 0);
        expectEq("midreset idle", int'(idle), 1);
        expectEq("midreset out_data", int'(out_data), 0);
        repeat (8) @(posedge clk);
        #1;
        expectEq("midreset no stale", obsQ.size(), nBefore);

        $display("[TB] randomized run");
        randReady = 1'b1;
        for (int batch = 0; batch < 6; batch++) begin
            waitDrain("random");
            a = int'($urandom_range(0, 255)) - 128;
            b = int'($urandom_range(0, 255)) - 128;
            setConfig(32'h4000_0000 + int'($urandom & 32'h3FFF_FFFF),
                      int'($urandom_range(0, 38)) - 31,
                      int'($urandom_range(0, 255)) - 128,
                      (a < b) ? a : b, (a < b) ? b : a);
            for (int k = 0; k < 40; k++) begin
                case ($urandom_range(0, 3))
                    0: acc = int'($urandom);
                    1: acc = int'($urandom_range(0, 600)) - 300;
                    2: acc = ($urandom_range(0, 1) == 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
                    default: acc = int'($urandom_range(0, 2097152)) - 1048576;
                endcase
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk); #1;
                    tickReady();
                end
                applyStimulus(acc, int'($urandom_range(0, 511)), int'($urandom_range(0, 511)),
                              refModel(acc, cfgMult, cfgShift, cfgZp, cfgMin, cfgMax), 1'b0);
            end
        end
        waitDrain("random");
        randReady = 1'b0;
        out_ready = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
